// File: rtl/alu_serial_pkg.sv
// ----------------------------------------------------------------------------
// alu_serial_pkg: operation and FSM state encodings shared by the serial ALU.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

package alu_serial_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_AND = 2'd1,
        OP_OR  = 2'd2,
        OP_XOR = 2'd3
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } alu_state_e;

endpackage

`default_nettype wire

// File: rtl/alu_slice.sv
// ----------------------------------------------------------------------------
// alu_slice: combinational SLICE-bit ripple ALU slice with carry inhibit.
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module alu_slice
    import alu_serial_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    input  logic             carry_in,
    input  logic             ic,
    input  alu_op_e          op,
    output logic [SLICE-1:0] res,
    output logic             carry_out,
    output logic             carry_msb
);

    always_comb begin : comb_slice
        logic c;
        logic cout_bit;
        res       = '0;
        carry_out = 1'b0;
        carry_msb = 1'b0;
        c         = ic ? 1'b0 : carry_in;
        for (int i = 0; i < SLICE; i++) begin
            cout_bit = (x[i] & y[i]) | ((x[i] ^ y[i]) & c);
            case (op)
                OP_ADD:  res[i] = x[i] ^ y[i] ^ c;
                OP_AND:  res[i] = x[i] & y[i];
                OP_OR:   res[i] = x[i] | y[i];
                default: res[i] = x[i] ^ y[i];
            endcase
            if (i == SLICE - 1) begin
                carry_msb = c;
                carry_out = cout_bit;
            end
            // Inhibit only gates the carry into the next bit, not the MSB carry out.
            c = ic ? 1'b0 : cout_bit;
        end
    end

endmodule

`default_nettype wire

// File: rtl/alu_serial.sv
// ----------------------------------------------------------------------------
// alu_serial: slice-serial ALU with valid/ready handshakes on both sides.
// Optional zf/nf/vf flag outputs when ALU_SERIAL_FLAGS_EN is defined. Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module alu_serial
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    input  logic             ci,
    input  logic             nb,
    input  logic             ic,
    input  logic             zb,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             co
`ifdef ALU_SERIAL_FLAGS_EN
    ,
    output logic             zf,
    output logic             nf,
    output logic             vf
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_SLICE = CW'(NSLICE - 1);

    generate
        if ((SLICE < 1) || (WIDTH % SLICE != 0)) begin : g_bad_slice
            $error("alu_serial: WIDTH must be a non-zero multiple of SLICE");
        end
    endgenerate

    alu_state_e       state, state_nxt;
    logic             accept;
    logic [WIDTH-1:0] x_q, y_q, res_q, res_nxt;
    alu_op_e          op_q;
    logic             ci_q, ic_q, carry_q, co_q;
    logic [CW-1:0]    cnt;
    logic [SLICE-1:0] xs, ys, rs;
    logic             s_cin, s_cout;
`ifdef ALU_SERIAL_FLAGS_EN
    logic             s_cmsb;
    logic             zf_q, nf_q, vf_q;
`else
    logic             s_cmsb_unused;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == LAST_SLICE) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    in_ready  = 1'b1;
                    state_nxt = in_valid ? RUN : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;
    assign xs     = x_q[int'(cnt)*SLICE +: SLICE];
    assign ys     = y_q[int'(cnt)*SLICE +: SLICE];
    assign s_cin  = (cnt == '0) ? ci_q : carry_q;

    alu_slice #(.SLICE(SLICE)) u_slice (
        .x         (xs),
        .y         (ys),
        .carry_in  (s_cin),
        .ic        (ic_q),
        .op        (op_q),
        .res       (rs),
        .carry_out (s_cout),
`ifdef ALU_SERIAL_FLAGS_EN
        .carry_msb (s_cmsb)
`else
        .carry_msb (s_cmsb_unused)
`endif
    );

    always_comb begin
        res_nxt = res_q;
        res_nxt[int'(cnt)*SLICE +: SLICE] = rs;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= OP_ADD;
            ci_q    <= 1'b0;
            ic_q    <= 1'b0;
            cnt     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            co_q    <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
            zf_q    <= 1'b0;
            nf_q    <= 1'b0;
            vf_q    <= 1'b0;
`endif
        end else if (accept) begin
            // Operand b is conditioned once at acceptance; slices then see y directly.
            x_q     <= a;
            y_q     <= (b & ~{WIDTH{zb}}) ^ {WIDTH{nb}};
            op_q    <= op;
            ci_q    <= ci;
            ic_q    <= ic;
            cnt     <= '0;
            carry_q <= 1'b0;
        end else if (state == RUN) begin
            res_q   <= res_nxt;
            carry_q <= s_cout;
            cnt     <= cnt + 1'b1;
            if (cnt == LAST_SLICE) begin
                co_q <= (op_q == OP_ADD) & s_cout;
`ifdef ALU_SERIAL_FLAGS_EN
                zf_q <= (res_nxt == '0);
                nf_q <= res_nxt[WIDTH-1];
                vf_q <= (op_q == OP_ADD) & (s_cmsb ^ s_cout);
`endif
            end
        end
    end

    assign out = res_q;
    assign co  = co_q;
`ifdef ALU_SERIAL_FLAGS_EN
    assign zf  = zf_q;
    assign nf  = nf_q;
    assign vf  = vf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_serial.sv
// ----------------------------------------------------------------------------
// tb_alu_serial: randomized and directed checks of alu_serial (16/4 and 32/32).
// Rev 1.0
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_alu_serial;
    import alu_serial_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // 16-bit, 4-bit slice instance
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, out;
    alu_op_e     op;
    logic        ci, nb, ic, zb, co;
    // 32-bit, single-slice instance
    logic        in_valid_w, in_ready_w, out_valid_w, out_ready_w;
    logic [31:0] a_w, b_w, out_w;
    alu_op_e     op_w;
    logic        ci_w, nb_w, ic_w, zb_w, co_w;
`ifdef ALU_SERIAL_FLAGS_EN
    logic        zf, nf, vf, zf_w, nf_w, vf_w;
`endif

    alu_serial #(.WIDTH(16), .SLICE(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .ci(ci), .nb(nb), .ic(ic), .zb(zb),
        .out_valid(out_valid), .out_ready(out_ready), .out(out), .co(co)
`ifdef ALU_SERIAL_FLAGS_EN
        , .zf(zf), .nf(nf), .vf(vf)
`endif
    );

    alu_serial #(.WIDTH(32), .SLICE(32)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_w), .in_ready(in_ready_w),
        .a(a_w), .b(b_w), .op(op_w), .ci(ci_w), .nb(nb_w), .ic(ic_w), .zb(zb_w),
        .out_valid(out_valid_w), .out_ready(out_ready_w), .out(out_w), .co(co_w)
`ifdef ALU_SERIAL_FLAGS_EN
        , .zf(zf_w), .nf(nf_w), .vf(vf_w)
`endif
    );

    logic [31:0] exp_out;
    logic        exp_co, exp_vf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Reference: plain arithmetic on a w-bit word.
    function automatic void model(input int w, input logic [31:0] xa, input logic [31:0] xb,
                                  input alu_op_e o, input logic c_i, input logic n_b,
                                  input logic i_c, input logic z_b,
                                  output logic [31:0] r, output logic c_o, output logic v);
        logic [31:0] mask, x, y;
        logic [32:0] sum;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        x    = xa & mask;
        y    = ((z_b ? 32'h0 : xb) ^ (n_b ? 32'hFFFF_FFFF : 32'h0)) & mask;
        c_o  = 1'b0;
        v    = 1'b0;
        case (o)
            OP_ADD: begin
                if (i_c) begin
                    r   = x ^ y;
                    c_o = x[w-1] & y[w-1];
                    v   = c_o;
                end else begin
                    sum = {1'b0, x} + {1'b0, y} + {32'h0, c_i};
                    r   = sum[31:0] & mask;
                    c_o = sum[w];
                    v   = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
                end
            end
            OP_AND:  r = x & y;
            OP_OR:   r = x | y;
            default: r = x ^ y;
        endcase
        r = r & mask;
    endfunction

    task automatic send16(input logic [15:0] ta, input logic [15:0] tb, input alu_op_e to,
                          input logic tci, input logic tnb, input logic tic, input logic tzb);
        int n;
        model(16, {16'h0, ta}, {16'h0, tb}, to, tci, tnb, tic, tzb, exp_out, exp_co, exp_vf);
        a = ta; b = tb; op = to; ci = tci; nb = tnb; ic = tic; zb = tzb;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // Scramble inputs after acceptance; the DUT must use the latched bundle.
        a = 16'($urandom); b = 16'($urandom); op = alu_op_e'(2'($urandom_range(0, 3)));
        ci = 1'($urandom); nb = 1'($urandom); ic = 1'($urandom); zb = 1'($urandom);
    endtask

    task automatic collect16(input int hold, input bit release_now);
        int cyc;
        cyc = 0;
        while (!out_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency16", cyc, 4);
        check("out16", out, exp_out[15:0]);
        check("co16", co, exp_co);
`ifdef ALU_SERIAL_FLAGS_EN
        check("zf16", zf, exp_out[15:0] == 16'h0);
        check("nf16", nf, exp_out[15]);
        check("vf16", vf, exp_vf);
`endif
        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            @(posedge clk);
            #1;
            check("hold16", {out_valid, in_ready, co, out}, {1'b1, 1'b0, exp_co, exp_out[15:0]});
        end
        if (release_now) begin
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            check("release16", out_valid, 0);
        end
    endtask

    task automatic run32(input logic [31:0] ta, input logic [31:0] tb, input alu_op_e to,
                         input logic tci, input logic tnb, input logic tic, input logic tzb);
        int n;
        int cyc;
        model(32, ta, tb, to, tci, tnb, tic, tzb, exp_out, exp_co, exp_vf);
        a_w = ta; b_w = tb; op_w = to; ci_w = tci; nb_w = tnb; ic_w = tic; zb_w = tzb;
        in_valid_w = 1'b1;
        n = 0;
        while (!in_ready_w && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout32", 0, 1);
        @(posedge clk);
        #1;
        in_valid_w = 1'b0;
        a_w = $urandom; b_w = $urandom;
        cyc = 0;
        while (!out_valid_w && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency32", cyc, 1);
        check("out32", out_w, exp_out);
        check("co32", co_w, exp_co);
`ifdef ALU_SERIAL_FLAGS_EN
        check("zf32", zf_w, exp_out == 32'h0);
        check("nf32", nf_w, exp_out[31]);
        check("vf32", vf_w, exp_vf);
`endif
        out_ready_w = 1'b1;
        @(posedge clk);
        #1;
        out_ready_w = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        in_valid = 0; out_ready = 0; a = 0; b = 0; op = OP_ADD; ci = 0; nb = 0; ic = 0; zb = 0;
        in_valid_w = 0; out_ready_w = 0; a_w = 0; b_w = 0; op_w = OP_ADD;
        ci_w = 0; nb_w = 0; ic_w = 0; zb_w = 0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out, 0);
        check("rst_co", co, 0);
`ifdef ALU_SERIAL_FLAGS_EN
        check("rst_flags", {zf, nf, vf}, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);

        // Directed cases
        send16(16'h1234, 16'h0001, OP_ADD, 0, 0, 0, 0); collect16(0, 1);
        send16(16'h0005, 16'h0007, OP_ADD, 1, 1, 0, 0); collect16(0, 1);
        send16(16'h0007, 16'h0005, OP_ADD, 1, 1, 0, 0); collect16(0, 1);
        send16(16'h8000, 16'h0001, OP_ADD, 1, 1, 0, 0); collect16(0, 1);
        send16(16'h00FF, 16'h0001, OP_ADD, 1, 0, 1, 0); collect16(0, 1);
        send16(16'h8000, 16'h8000, OP_ADD, 0, 0, 1, 0); collect16(0, 1);
        send16(16'h0000, 16'h1234, OP_ADD, 0, 1, 0, 1); collect16(0, 1);

        // Back-pressure, then release and accept a new bundle on the same edge
        send16(16'h1111, 16'h2222, OP_ADD, 0, 0, 0, 0);
        collect16(5, 0);
        out_ready = 1'b1;
        send16(16'hA5A5, 16'h0FF0, OP_XOR, 0, 0, 0, 0);
        out_ready = 1'b0;
        check("overlap_out_valid", out_valid, 0);
        check("overlap_in_ready", in_ready, 0);
        collect16(0, 1);

        // Reset during slice 2
        send16(16'h1234, 16'h4321, OP_ADD, 0, 0, 0, 0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrun_out_valid", out_valid, 0);
        check("midrun_out", out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1);
        send16(16'hFFFF, 16'h0001, OP_ADD, 0, 0, 0, 0); collect16(0, 1);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            send16(16'($urandom), 16'($urandom), alu_op_e'(2'($urandom_range(0, 3))),
                   1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            collect16($urandom_range(0, 3), 1'b1);
        end

        // Single-slice configuration
        run32(32'hF0F0F0F0, 32'hFF00FF00, OP_AND, 0, 0, 0, 0);
        run32(32'hF0F0F0F0, 32'hFF00FF00, OP_OR,  0, 0, 0, 0);
        run32(32'hF0F0F0F0, 32'hFF00FF00, OP_XOR, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) begin
            run32($urandom, $urandom, alu_op_e'(2'($urandom_range(0, 3))),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_serial.md
Name: alu_serial

Overview:
- Multi-cycle, slice-serial ALU; parametrised successor to the combinational 16-bit ripple ALU.
- Keeps the same operand-conditioning controls: ci, nb, ic, zb.
- Adds logic ops, parametrised width, and a configurable slice width processed per cycle.
- Adds valid/ready handshakes on input and output, so it sits between the register file and the writeback stage with back-pressure.

Parameters:
- WIDTH, 16, operand/result width in bits.
- SLICE, 4, bits processed per cycle; WIDTH % SLICE must equal 0; elaboration error otherwise.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand bundle valid.
- in_ready  output  1  block accepts bundle this cycle.
- a  input  WIDTH  operand x.
- b  input  WIDTH  operand b, before conditioning.
- op  input  2  operation select (package enum).
- ci  input  1  carry into bit 0.
- nb  input  1  invert conditioned b.
- ic  input  1  inhibit all carries.
- zb  input  1  zero b before inversion.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- out  output  WIDTH  result.
- co  output  1  carry out of MSB.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Conditioning: y = (b & ~{WIDTH{zb}}) ^ {WIDTH{nb}}.
- Carry into bit i:
  - ic ? 0 : (i==0 ? ci : carry_out[i-1]).
  - carry_out[i] = (x&y) | ((x^y)&carry[i]).
- op encodings:
  - OP_ADD: out = x^y^carry; co = carry_out[WIDTH-1].
  - OP_AND: out = x&y; co = 0.
  - OP_OR: out = x|y; co = 0.
  - OP_XOR: out = x^y; co = 0.
- ic=1 with OP_ADD: out = x^y and co = x[MSB]&y[MSB]. ci is ignored.
- Operands and controls are latched on acceptance (in_valid & in_ready); later input changes have no effect.
- FSM states: IDLE, RUN, DONE.
  - IDLE: in_ready=1. On accept, latch the bundle, clear slice counter and carry register, go to RUN.
  - RUN: each cycle compute slice k (bits k*SLICE+SLICE-1 .. k*SLICE), LSB slice first, using the registered carry from slice k-1. Store the slice into the result register and update the carry register. At k = WIDTH/SLICE-1, go to DONE.
  - DONE: out_valid=1, out/co stable. On out_ready, go to IDLE.
  - DONE with out_ready=1 and in_valid=1 in the same cycle: the new bundle is accepted and the FSM goes directly to RUN. in_ready = (IDLE) | (DONE & out_ready).
- Latency: out_valid rises WIDTH/SLICE cycles after the accepting edge.
  - SLICE==WIDTH gives a single RUN cycle.
  - Peak throughput: one op per WIDTH/SLICE+1 cycles.
- in_ready=0 in RUN and in DONE while out_ready=0.
- Back-pressure: out, co and flags hold stable while out_valid & ~out_ready.
- Reset values: out_valid=0, out=0, co=0, all flags 0, state IDLE, in_ready=1 after release.
- Reset mid-RUN or mid-DONE discards the operation; no partial result is ever presented.

Optional Feature:
- Macro: ALU_SERIAL_FLAGS_EN.
- When defined, add output ports:
  - zf (1): out == 0.
  - nf (1): out[WIDTH-1].
  - vf (1): OP_ADD ? carry[WIDTH-1] ^ carry_out[WIDTH-1] : 0.
- Flags are registered with the result and valid in DONE.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_serial_pkg:
  - alu_op_e (OP_ADD=0, OP_AND=1, OP_OR=2, OP_XOR=3).
  - alu_state_e (IDLE, RUN, DONE).
- Sub-module alu_slice: combinational, parametrised by SLICE.
  - Inputs: x/y slice, carry_in, ic, op.
  - Outputs: result slice, carry_out, carry into slice MSB (for vf).
  - Top level owns FSM, counter, operand/result registers and carry register.

Test Plan:
- Basic add, WIDTH=16/SLICE=4: a=0x1234, b=0x0001, OP_ADD, all ctrl 0 -> out=0x1235, co=0; out_valid exactly 4 cycles after accept.
- Subtract, nb=1 and ci=1:
  - a=0x0005, b=0x0007 -> out=0xFFFE, co=0, vf=0.
  - a=0x0007, b=0x0005 -> out=0x0002, co=1.
  - a=0x8000, b=0x0001 -> out=0x7FFF, vf=1.
- Carry inhibit and conditioning:
  - ic=1, ci=1: a=0x00FF, b=0x0001 -> out=0x00FE, co=0.
  - ic=1: a=0x8000, b=0x8000 -> out=0x0000, co=1, zf=1.
  - zb=1, nb=1: a=0x0000 -> out=0xFFFF, nf=1.
- Back-pressure: hold out_ready=0 for 5 cycles in DONE -> out/co stable, in_ready=0. Then out_ready=1 with in_valid=1 -> new bundle accepted that cycle, next result correct.
- Reset: assert rst_n=0 during RUN slice 2 -> out_valid=0, out=0 immediately; after release in_ready=1 and next op a=0xFFFF, b=0x0001 ADD -> out=0x0000, co=1.
- Config WIDTH=32/SLICE=32, OP_AND: a=0xF0F0F0F0, b=0xFF00FF00 -> out=0xF000F000, co=0, latency 1 cycle. Repeat OP_OR/OP_XOR -> 0xFFF0FFF0 / 0x0FF00FF0.
